// File: rtl/sequence_controller.sv
// Control sequencer for the basic RISC CPU: decodes opcode against the current phase
// into registered datapath strobes, owns the sticky halt and counts retired instructions.
module sequence_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       PHASE,
    input  logic [2:0]       OPCODE,
    input  logic             ZERO,
    input  logic             GO,
    output logic             PH_EN,
    output logic             SEL,
    output logic             RD,
    output logic             LD_IR,
    output logic             INC_PC,
    output logic             LD_PC,
    output logic             LD_AC,
    output logic             DATA_E,
    output logic             WR,
    output logic             HALT,
    output logic [CNT_W-1:0] INSTR_CNT
);

    localparam logic [1:0] PhFetch   = 2'd0;
    localparam logic [1:0] PhDecode  = 2'd1;
    localparam logic [1:0] PhExecute = 2'd2;
    localparam logic [1:0] PhUpdate  = 2'd3;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    typedef enum logic {StRun, StHalted} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, rd_q, ld_ir_q, inc_pc_q, ld_pc_q, ld_ac_q, data_e_q, wr_q;
    logic             sel_d, rd_d, ld_ir_d, inc_pc_d, ld_pc_d, ld_ac_d, data_e_d, wr_d;
    logic [2:0]       op_use;
    logic             alu_op;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sel_d    = 1'b0;
        rd_d     = 1'b0;
        ld_ir_d  = 1'b0;
        inc_pc_d = 1'b0;
        ld_pc_d  = 1'b0;
        ld_ac_d  = 1'b0;
        data_e_d = 1'b0;
        wr_d     = 1'b0;

        // The live opcode is only trusted during DECODE; later phases use the latched copy.
        op_use = (PHASE == PhDecode) ? OPCODE : op_q;
        alu_op = (op_use == OpAdd) || (op_use == OpAnd) || (op_use == OpXor) ||
                 (op_use == OpLda);

        unique case (state_q)
            StRun:    if (PHASE == PhDecode && OPCODE == OpHlt) state_d = StHalted;
            StHalted: if (GO) state_d = StRun;
            default:  state_d = StRun;
        endcase

        if (PHASE == PhDecode) op_d = OPCODE;
        if (state_q == StRun && PHASE == PhUpdate) cnt_d = cnt_q + CNT_W'(1);

        if (state_d == StRun) begin
            unique case (PHASE)
                PhFetch: begin
                    sel_d   = 1'b1;
                    rd_d    = 1'b1;
                    ld_ir_d = 1'b1;
                end
                PhDecode: inc_pc_d = 1'b1;
                PhExecute: begin
                    rd_d     = alu_op;
                    data_e_d = (op_use == OpSto);
                    ld_pc_d  = (op_use == OpJmp);
                    inc_pc_d = (op_use == OpSkz) && ZERO;
                end
                PhUpdate: begin
                    rd_d     = alu_op;
                    ld_ac_d  = alu_op;
                    data_e_d = (op_use == OpSto);
                    wr_d     = (op_use == OpSto);
                    ld_pc_d  = (op_use == OpJmp);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StRun;
            op_q     <= OpHlt;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            rd_q     <= 1'b0;
            ld_ir_q  <= 1'b0;
            inc_pc_q <= 1'b0;
            ld_pc_q  <= 1'b0;
            ld_ac_q  <= 1'b0;
            data_e_q <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            ld_ir_q  <= ld_ir_d;
            inc_pc_q <= inc_pc_d;
            ld_pc_q  <= ld_pc_d;
            ld_ac_q  <= ld_ac_d;
            data_e_q <= data_e_d;
            wr_q     <= wr_d;
        end
    end

    assign HALT      = (state_q == StHalted);
    assign PH_EN     = (state_q == StRun);
    assign SEL       = sel_q;
    assign RD        = rd_q;
    assign LD_IR     = ld_ir_q;
    assign INC_PC    = inc_pc_q;
    assign LD_PC     = ld_pc_q;
    assign LD_AC     = ld_ac_q;
    assign DATA_E    = data_e_q;
    assign WR        = wr_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
- Downstream consumer of the 4-phase generator's PHASE output (FETCH, DECODE, EXECUTE, UPDATE).
- Decodes the 3-bit instruction opcode against the current phase and drives registered datapath control strobes for the basic RISC CPU.
- Owns the sticky halt condition and gates the phase generator through PH_EN.
- Keeps a retired-instruction counter for bring-up and verification.

Parameters:
CNT_W, 16, width of the retired-instruction counter INSTR_CNT

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous active-high reset, sampled on rising CLK
PHASE  input  2  current phase from phase generator: FETCH=0, DECODE=1, EXECUTE=2, UPDATE=3
OPCODE  input  3  IR opcode field: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
ZERO  input  1  accumulator-zero flag from ALU
GO  input  1  single-cycle restart request; clears halt
PH_EN  output  1  enable to phase generator; low while halted
SEL  output  1  address mux select: 1 = PC, 0 = IR address
RD  output  1  memory read strobe
LD_IR  output  1  instruction register load
INC_PC  output  1  program counter increment
LD_PC  output  1  program counter load (jump)
LD_AC  output  1  accumulator load
DATA_E  output  1  data bus output enable (store)
WR  output  1  memory write strobe
HALT  output  1  halt status; equals internal halted flag
INSTR_CNT  output  CNT_W  retired-instruction count

Behaviour:
- Clocking and reset: one clock domain (CLK). Reset is synchronous and active-high (RST).
- Reset (RST=1 at rising edge):
  - All strobes (SEL, RD, LD_IR, INC_PC, LD_PC, LD_AC, DATA_E, WR) go to 0.
  - HALT=0, PH_EN=1, INSTR_CNT=0, internal OP_Q=0.
  - RST has priority over every other input, including mid-instruction and while halted.
- Latency: all strobes are registered. Strobes valid in cycle t+1 are decoded from PHASE/OPCODE/ZERO sampled in cycle t (exactly 1 cycle).
- Opcode capture: when PHASE==DECODE, OPCODE is both used for decode and latched into OP_Q. In EXECUTE and UPDATE, OP_Q is used and OPCODE is ignored.
- ALU class: ADD, AND, XOR, LDA.
- Decode table (inputs not listed produce 0):
  - FETCH: SEL=1, RD=1, LD_IR=1.
  - DECODE: INC_PC=1. If OPCODE==HLT, set halted.
  - EXECUTE:
    - ALU class: RD=1.
    - STO: DATA_E=1.
    - JMP: LD_PC=1.
    - SKZ with ZERO=1: INC_PC=1. SKZ with ZERO=0: nothing.
  - UPDATE:
    - ALU class: RD=1, LD_AC=1.
    - STO: DATA_E=1, WR=1.
    - JMP: LD_PC=1.
- Halt state machine, states RUN and HALTED:
  - RUN -> HALTED on the edge that samples PHASE==DECODE with OPCODE==HLT.
  - HALTED -> RUN on the edge sampling GO=1.
  - HALTED: HALT=1, PH_EN=0, all strobes 0 (registered). The phase generator freezes at EXECUTE, since its transition on the halting edge still had EN high.
  - After GO, the phase sequence resumes EXECUTE, UPDATE with OP_Q=HLT (no strobes), then FETCH.
  - GO while in RUN: ignored. GO and a HLT decode on the same edge: halt wins.
- Counter:
  - INSTR_CNT increments by 1 on each edge sampling PHASE==UPDATE while not halted.
  - The HLT instruction's own UPDATE after resume counts.
  - Wraps from 2^CNT_W-1 to 0 silently.
- No illegal-phase handling is needed: the 2-bit encoding is fully used.

Test Plan:
- Reset: assert RST for 2 cycles mid-EXECUTE of STO with PHASE=2 -> next cycle all strobes 0, HALT=0, PH_EN=1, INSTR_CNT=0.
- ADD sequence: PHASE 0,1,2,3 with OPCODE=2 at DECODE -> strobes one cycle later:
  - {SEL,RD,LD_IR}=1
  - INC_PC=1
  - RD=1
  - {RD,LD_AC}=1
  - INSTR_CNT 0->1.
- STO then JMP, with OPCODE changed to 0 during EXECUTE (proves OP_Q use) -> STO: EXECUTE DATA_E=1, UPDATE DATA_E=WR=1. JMP: LD_PC=1 in both EXECUTE and UPDATE. No halt.
- SKZ: ZERO=1 at EXECUTE -> INC_PC=1. Repeat with ZERO=0 -> INC_PC=0.
- HLT at DECODE -> next cycle HALT=1, PH_EN=0, all strobes 0; hold 5 cycles with PHASE=2 -> unchanged, counter frozen. GO=1 for 1 cycle -> HALT=0, PH_EN=1; following UPDATE increments INSTR_CNT.
- Wrap with CNT_W=4: run 16 instructions -> INSTR_CNT returns to 0. GO and HLT-at-DECODE on the same edge -> HALT=1.
